// File: rtl/olink_rx_framer.sv
// ----------------------------------------------------------------------------
// olink_rx_framer
//
// Receive-side framer for a 16-bit GT lane. Incoming beats are grouped into
// frames of RATIO beats. Alignment is found from K28.5 commas (8'hBC with only
// byte 0 flagged as K) and a frame is emitted once the last beat of the
// frame has been captured.
//
// Alignment states:
//   HUNT   (0) - no frames emitted; a comma starts a frame and enters SYNC.
//   SYNC   (1) - frames emitted (never valid); phase-0 commas are counted and
//                LOCK_COUNT of them enter LOCKED. A misaligned comma realigns.
//   LOCKED (2) - frames emitted and qualified; UNLOCK_ERRS consecutive bad
//                frames drop back to HUNT. Misaligned commas do not realign.
// A low rx_reset_done forces HUNT from any state.
//
// Parameters:
//   RATIO       - 16-bit beats per output frame (2 or 4)
//   LOCK_COUNT  - consecutive phase-0 commas needed to lock
//   UNLOCK_ERRS - consecutive errored frames that force unlock
//   CNT_W       - width of the saturating status counters
//
// Ports:
//   clk_link      - link user clock, the only clock
//   reset         - synchronous, active-high reset
//   rx_d          - GT receive data, byte 0 in [7:0]
//   rx_k          - per-byte K flags
//   rx_nit        - per-byte not-in-table flags
//   rx_reset_done - GT RX reset done; low marks beats as errored
//   cnt_clear     - synchronous clear of bad_count / unlock_count
//   out_d         - assembled frame, first beat in the LSBs
//   out_k         - K flags aligned with out_d
//   out_strobe    - one-cycle pulse per emitted frame
//   out_v         - frame good, qualified by out_strobe
//   state         - 0=HUNT, 1=SYNC, 2=LOCKED
//   bad_count     - errored beats seen (saturating)
//   unlock_count  - LOCKED->HUNT transitions (saturating)
// ----------------------------------------------------------------------------
module olink_rx_framer #(
    parameter int RATIO       = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic                clk_link,
    input  logic                reset,
    input  logic [15:0]         rx_d,
    input  logic [1:0]          rx_k,
    input  logic [1:0]          rx_nit,
    input  logic                rx_reset_done,
    input  logic                cnt_clear,
    output logic [16*RATIO-1:0] out_d,
    output logic [2*RATIO-1:0]  out_k,
    output logic                out_strobe,
    output logic                out_v,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    bad_count,
    output logic [CNT_W-1:0]    unlock_count
);

    localparam int FD_W = 16 * RATIO;
    localparam int FK_W = 2 * RATIO;
    localparam int PH_W = (RATIO > 2) ? 2 : 1;
    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam int EC_W = $clog2(UNLOCK_ERRS + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic [LC_W-1:0]   r_good_cnt;     // consecutive phase-0 commas in SYNC
    logic [EC_W-1:0]   r_efc;          // consecutive errored frames in LOCKED
    logic [FD_W-1:0]   r_acc_d;        // frame being assembled
    logic [FK_W-1:0]   r_acc_k;
    logic              r_frm_err;      // error beat seen in current frame
    logic              r_frm_mis;      // misaligned comma seen in current frame
    logic [FD_W-1:0]   r_out_d;
    logic [FK_W-1:0]   r_out_k;
    logic              r_out_strobe;
    logic              r_out_v;
    logic [CNT_W-1:0]  r_bad_cnt;
    logic [CNT_W-1:0]  r_unlock_cnt;

    // ------------------------------------------------------------------
    // Beat classification and frame assembly
    // ------------------------------------------------------------------
    logic              w_comma;
    logic              w_err;
    logic              w_realign;
    logic [PH_W-1:0]   w_slot;
    logic              w_last;
    logic [PH_W-1:0]   w_phase_next;
    logic              w_mis_beat;
    logic              w_frm_err;
    logic              w_frm_mis;
    logic [FD_W-1:0]   w_frame_d;
    logic [FK_W-1:0]   w_frame_k;
    logic              w_first_comma;
    logic              w_pass;
    logic              w_emit;
    logic              w_good;
    logic              w_efc_full;
    logic              w_err_unlock;
    logic              w_unlock;
    logic [FD_W-1:0]   w_pad_d;

    assign w_comma = (rx_k == 2'b01) && (rx_d[7:0] == 8'hBC);
    assign w_err   = (rx_nit != 2'b00) || !rx_reset_done;

    // A comma in HUNT, or off phase 0 in SYNC, becomes beat 0 of a new frame.
    assign w_realign = w_comma &&
                       ((r_state == ST_HUNT) ||
                        ((r_state == ST_SYNC) && (r_phase != '0)));

    // Slot this beat lands in; on realignment the partial frame is dropped.
    assign w_slot       = w_realign ? '0 : r_phase;
    assign w_last       = (w_slot == PH_LAST);
    assign w_phase_next = w_last ? '0 : w_slot + 1'b1;

    // In LOCKED a misaligned comma only taints the frame.
    assign w_mis_beat = w_comma && (r_state == ST_LOCKED) && (r_phase != '0);

    // Frame flags restart at slot 0 so stale history never leaks forward.
    assign w_frm_err = w_err || ((w_slot != '0) && r_frm_err);
    assign w_frm_mis = w_mis_beat || ((w_slot != '0) && r_frm_mis);

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
        localparam logic [PH_W-1:0] SLOT = PH_W'(gi);
        assign w_frame_d[gi*16 +: 16] = (w_slot == SLOT) ? rx_d : r_acc_d[gi*16 +: 16];
        assign w_frame_k[gi*2 +: 2]   = (w_slot == SLOT) ? rx_k : r_acc_k[gi*2 +: 2];
    end

    // Mixed K patterns cannot be forwarded meaningfully; replace with K28.0.
    assign w_first_comma = (w_frame_k[1:0] == 2'b01) && (w_frame_d[7:0] == 8'hBC);
    assign w_pass        = (w_frame_k == '0) || (w_frame_k == '1) || w_first_comma;
    assign w_pad_d       = {(2*RATIO){8'h1C}};

    // A beat with rx_reset_done low drives the framer to HUNT, so no frame
    // is produced from it.
    assign w_emit = w_last && rx_reset_done &&
                    ((r_state == ST_SYNC) || (r_state == ST_LOCKED));
    assign w_good = (r_state == ST_LOCKED) && !w_frm_err && !w_frm_mis;

    assign w_efc_full   = (int'(r_efc) + 1 >= UNLOCK_ERRS);
    assign w_err_unlock = w_emit && (r_state == ST_LOCKED) && !w_good && w_efc_full;
    assign w_unlock     = w_err_unlock || (!rx_reset_done && (r_state == ST_LOCKED));

    // ------------------------------------------------------------------
    // Alignment FSM, frame assembly and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_link) begin
        if (reset) begin
            r_state      <= ST_HUNT;
            r_phase      <= '0;
            r_good_cnt   <= '0;
            r_efc        <= '0;
            r_acc_d      <= '0;
            r_acc_k      <= '0;
            r_frm_err    <= 1'b0;
            r_frm_mis    <= 1'b0;
            r_out_d      <= '0;
            r_out_k      <= '0;
            r_out_strobe <= 1'b0;
            r_out_v      <= 1'b0;
        end else begin
            r_phase   <= w_phase_next;
            r_acc_d   <= w_frame_d;
            r_acc_k   <= w_frame_k;
            r_frm_err <= w_frm_err;
            r_frm_mis <= w_frm_mis;

            r_out_strobe <= w_emit;
            r_out_v      <= w_emit && w_good;
            if (w_emit) begin
                r_out_d <= w_pass ? w_frame_d : w_pad_d;
                r_out_k <= w_pass ? w_frame_k : '1;
            end

            if (!rx_reset_done) begin
                r_state    <= ST_HUNT;
                r_good_cnt <= '0;
                r_efc      <= '0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_comma) begin
                            r_state    <= ST_SYNC;
                            r_good_cnt <= LC_W'(1);
                        end
                    end
                    ST_SYNC: begin
                        if (w_comma) begin
                            if (r_phase == '0) begin
                                if (int'(r_good_cnt) + 1 >= LOCK_COUNT) begin
                                    r_state    <= ST_LOCKED;
                                    r_good_cnt <= '0;
                                    r_efc      <= '0;
                                end else begin
                                    r_good_cnt <= r_good_cnt + 1'b1;
                                end
                            end else begin
                                r_good_cnt <= LC_W'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_emit) begin
                            if (w_good) begin
                                r_efc <= '0;
                            end else if (w_err_unlock) begin
                                r_state <= ST_HUNT;
                                r_efc   <= '0;
                            end else begin
                                r_efc <= r_efc + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_HUNT;
                        r_good_cnt <= '0;
                        r_efc      <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating status counters; clear wins over increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk_link) begin
        if (reset || cnt_clear) begin
            r_bad_cnt    <= '0;
            r_unlock_cnt <= '0;
        end else begin
            if (w_err && (r_bad_cnt != '1)) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
            end
            if (w_unlock && (r_unlock_cnt != '1)) begin
                r_unlock_cnt <= r_unlock_cnt + 1'b1;
            end
        end
    end

    assign out_d        = r_out_d;
    assign out_k        = r_out_k;
    assign out_strobe   = r_out_strobe;
    assign out_v        = r_out_v;
    assign state        = r_state;
    assign bad_count    = r_bad_cnt;
    assign unlock_count = r_unlock_cnt;

endmodule

// File: doc/olink_rx_framer.md
OLINK_RX_FRAMER -- requirements
Module: olink_rx_framer

Interface
REQ-001 SHALL have parameter RATIO, default 2, meaning the number of 16-bit GT beats per output frame; legal values are 2 and 4.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive phase-0 commas required to lock.
REQ-003 SHALL have parameter UNLOCK_ERRS, default 8, meaning the number of consecutive errored frames that forces unlock.
REQ-004 SHALL have parameter CNT_W, default 32, meaning the width of the status counters.
REQ-005 SHALL have port clk_link, input, 1 bit: the link user clock; all logic runs in this domain.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port rx_d, input, 16 bits: GT receive data, with byte 0 in bits [7:0].
REQ-008 SHALL have port rx_k, input, 2 bits: per-byte K flags.
REQ-009 SHALL have port rx_nit, input, 2 bits: per-byte not-in-table flags.
REQ-010 SHALL have port rx_reset_done, input, 1 bit: GT RX reset done.
REQ-011 SHALL have port cnt_clear, input, 1 bit: synchronous clear of the counters.
REQ-012 SHALL have port out_d, output, 16*RATIO bits: assembled frame; first beat in the LSBs.
REQ-013 SHALL have port out_k, output, 2*RATIO bits: K flags aligned with out_d.
REQ-014 SHALL have port out_strobe, output, 1 bit: one-cycle pulse per emitted frame.
REQ-015 SHALL have port out_v, output, 1 bit: frame good, qualified by out_strobe.
REQ-016 SHALL have port state, output, 2 bits: 0=HUNT, 1=SYNC, 2=LOCKED.
REQ-017 SHALL have port bad_count, output, CNT_W bits: count of errored beats.
REQ-018 SHALL have port unlock_count, output, CNT_W bits: count of LOCKED->HUNT transitions.

Function
REQ-019 SHALL define a comma beat as rx_k==2'b01 and rx_d[7:0]==8'hBC.
REQ-020 SHALL define an error beat as rx_nit!=0 or rx_reset_done==0.
REQ-021 SHALL keep a beat phase counter counting 0..RATIO-1 and wrapping to 0; a comma in HUNT sets the next phase to 1.
REQ-022 SHALL, in HUNT, emit no strobes and transition to SYNC on a comma, with the good-comma count set to 1.
REQ-023 SHALL, in SYNC, increment the good-comma count on a comma at phase 0, and enter LOCKED when the count reaches LOCK_COUNT.
REQ-024 SHALL, in SYNC, treat a comma at phase !=0 as a realignment: the next phase is 1 and the count is set to 1.
REQ-025 SHALL, in SYNC or LOCKED, emit a frame when the beat at phase RATIO-1 is captured; out_strobe is high on the following cycle (latency = 1 cycle after the last beat).
REQ-026 SHALL pass frame content unchanged when its K pattern is all-zero, all-ones, or the frame starts with a comma; otherwise out_d SHALL be replicated 8'h1C and out_k all-ones.
REQ-027 SHALL set out_v=1 only when state is LOCKED at emission, the frame has no error beat, and no comma occurred at phase !=0 within the frame.
REQ-028 SHALL, in LOCKED, increment a consecutive-errored-frame count on each frame with out_v=0 and clear it on each frame with out_v=1.
REQ-029 SHALL transition to HUNT and increment unlock_count when the errored-frame count reaches UNLOCK_ERRS.
REQ-030 SHALL, in LOCKED, not realign on a misaligned comma; that comma only marks the frame as errored.
REQ-031 SHALL force HUNT from any state in the cycle after rx_reset_done==0; a forced exit from LOCKED counts as an unlock.
REQ-032 SHALL, in HUNT, keep out_v=0 and out_strobe=0, while out_d and out_k hold their last values.
REQ-033 SHALL increment bad_count once per error beat in any state.
REQ-034 SHALL make bad_count and unlock_count saturate at all-ones.
REQ-035 SHALL give cnt_clear priority over a simultaneous increment; the counters read 0 on the next cycle.
REQ-036 SHALL, when a comma and an error beat coincide, treat the beat as errored and still honour the comma for alignment in HUNT and SYNC.

Reset
REQ-037 SHALL, on reset, make state HUNT, phase 0, all internal counts 0, out_d, out_k, out_strobe and out_v 0, and bad_count and unlock_count 0.
REQ-038 SHALL give reset priority over all other inputs, including in mid-frame; a partial frame is discarded and not emitted.

Verification
REQ-039 Bench SHALL cover clean lock: with RATIO=2, a comma every 4 beats plus data -> state reaches 2 after the 4th phase-0 comma; out_strobe every 2nd cycle with out_v=1 and out_d={beat1,beat0}.
REQ-040 Bench SHALL cover realignment: in SYNC, a comma at phase 1 -> count set to 1, the next frame is aligned to the new comma, and state stays 1.
REQ-041 Bench SHALL cover unlock: in LOCKED, rx_nit=2'b01 on 8 consecutive frames -> state becomes 0 and unlock_count increments by 1; bad_count increments by 8 or more.
REQ-042 Bench SHALL cover padding: a mixed K frame (out_k pattern 2'b10 on a non-comma beat) -> out_d=32'h1C1C1C1C and out_k=4'hF.
REQ-043 Bench SHALL cover saturation and clear: preload bad_count near max via forced errors with CNT_W=4 -> it holds at 4'hF; cnt_clear together with an error beat -> the count reads 0.
REQ-044 Bench SHALL cover mid-frame reset: assert reset at phase 1 with RATIO=4 -> no strobe is emitted, all outputs are 0, and state is 0 on the next cycle.
